program_loader: RTL

- Upstream feeder for the 8-bit CPU programming interface.
- Accepts a program image of PROG_BYTES bytes from a host byte stream using valid/ready, and buffers the whole image.
- Once the image is complete, drives the CPU programming pins: prog_mode goes to uio_in[0] and prog_data goes to ui_in.
- Streams one byte per CPU ready pulse, then waits for the CPU's done_load before releasing programming mode.

---
 rtl/program_loader_pkg.sv | 22 ++
 rtl/prog_byte_buffer.sv | 36 +++
 rtl/program_loader.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared state encoding and default sizes for the program loader
package program_loader_pkg;

  localparam int PROG_BYTES_DEF = 16;
  localparam int DATA_W_DEF     = 8;
  localparam int PTR_W_DEF      = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_PROGRAM,
    ST_WAIT_DONE,
    ST_DONE,
    ST_ERROR
  } state_e;

  // States in which the host stream may hand over a byte.
  function automatic logic accepts_host(input state_e s);
    return (s == ST_IDLE) || (s == ST_FILL) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/prog_byte_buffer.sv
// rtl/prog_byte_buffer.sv - image register file, one write port and a registered read port
module prog_byte_buffer #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int PTR_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [PTR_W-1:0]  wr_ptr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  rd_ptr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_ptr] <= wdata;
    end
  end

  // Only the read register is cleared so the CPU-facing byte is defined out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[rd_ptr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - buffers a host image and streams it into the CPU programming pins
// Optional trailing checksum byte: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int PROG_BYTES = PROG_BYTES_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PTR_W      = PTR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              cpu_ready,
  input  logic              cpu_done_load,
  output logic              prog_mode,
  output logic [DATA_W-1:0] prog_data,
  output logic              busy,
  output logic              loaded,
  output logic              error,
  output logic [PTR_W:0]    byte_count
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PROG_BYTES - 1);
  localparam logic [PTR_W-1:0] RD_LAST  = PTR_W'(PROG_BYTES - 1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PROG_BYTES);
`endif

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic                prog_mode_q, prog_mode_d;
  logic                in_ready_q, in_ready_d;
  logic                host_accept;
  logic                buf_we;
  logic [PTR_W-1:0]    buf_wr_ptr;
  logic [DATA_W-1:0]   buf_rdata;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_q, sum_d;
`endif

  assign host_accept = in_valid && in_ready_q && !abort;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    buf_we     = 1'b0;
    buf_wr_ptr = cnt_q[PTR_W-1:0];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (host_accept) begin
          state_d    = ST_FILL;
          buf_we     = 1'b1;
          buf_wr_ptr = '0;
          cnt_d      = CNT_W'(1);
          rd_ptr_d   = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d      = in_data;
`endif
        end
      end
      ST_FILL: begin
        if (host_accept) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          // Once the image is full, the next byte is the checksum and is not stored.
          if (cnt_q == CNT_FULL) begin
            state_d = (in_data == sum_q) ? ST_PROGRAM : ST_ERROR;
            cnt_d   = '0;
          end else begin
            buf_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            sum_d  = sum_q + in_data;
          end
`else
          buf_we = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_PROGRAM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      ST_PROGRAM: begin
        if (cpu_done_load) begin
          state_d = ST_ERROR;
        end else if (cpu_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (rd_ptr_q != RD_LAST) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
          if (cnt_q == CNT_LAST) begin
            state_d = ST_WAIT_DONE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (cpu_done_load) begin
          state_d = ST_DONE;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      rd_ptr_d = '0;
      buf_we   = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_d    = '0;
`endif
    end

    // Both pins are registered copies of what the next state wants.
    prog_mode_d = (state_d == ST_PROGRAM) || (state_d == ST_WAIT_DONE);
    in_ready_d  = accepts_host(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      prog_mode_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      prog_mode_q <= prog_mode_d;
      in_ready_q  <= in_ready_d;
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif

  // Read address is the next pointer so the byte lands in the cycle after each ready pulse.
  prog_byte_buffer #(
    .DEPTH  (PROG_BYTES),
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W)
  ) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (buf_we),
    .wr_ptr (buf_wr_ptr),
    .wdata  (in_data),
    .rd_ptr (rd_ptr_d),
    .rdata  (buf_rdata)
  );

  assign in_ready   = in_ready_q;
  assign prog_mode  = prog_mode_q;
  assign prog_data  = prog_mode_q ? buf_rdata : '0;
  assign busy       = (state_q == ST_FILL) || (state_q == ST_PROGRAM) || (state_q == ST_WAIT_DONE);
  assign loaded     = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERROR);
  assign byte_count = cnt_q;

endmodule
